// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: mode encoding and group-count helper.
package adder_pkg;

  // Operation mode captured per transaction.
  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  // Number of carry-skip groups (pipeline stages) for a given width/group size.
  function automatic int num_groups(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/carry_skip_group.sv
// One carry-skip group: bitwise P/G, ripple chain, skip mux on the carry-out, sum bits.
// Purely combinational; the pipeline registers live in the parent.
module carry_skip_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             grp_p;

  assign p     = a ^ b;
  assign g     = a & b;
  assign grp_p = &p;

  // Ripple carry through the group, bit by bit.
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[GROUP-1:0];
  // When every bit propagates, the incoming carry bypasses the ripple chain.
  assign cout = grp_p ? cin : c[GROUP];

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor. Rank 0 captures the operands (with B
// inverted for subtraction), stage k resolves group k from rank k into rank k+1,
// and the last stage loads the output registers. Operand bits above the active
// group ride along (skew) and finished sum bits below it ride along (deskew), so a
// whole transaction leaves in one cycle. A single advance signal stalls everything.
module pipelined_carry_skip_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:1] A,
  input  logic [WIDTH:1] B,
  input  logic           Cin,
  input  logic           Sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:1] S,
  output logic           Cout,
  output logic           Ovf
);

  localparam int NUM_GROUPS = num_groups(WIDTH, GROUP);

  if (WIDTH % GROUP != 0) begin : g_bad_group
    $error("WIDTH must be a multiple of GROUP");
  end

  logic                                advance;
  logic                                sub_mode;
  logic [NUM_GROUPS-1:0]               vld_p;
  logic [WIDTH:1]                      a_p [NUM_GROUPS];
  logic [WIDTH:1]                      b_p [NUM_GROUPS];
  logic [WIDTH:1]                      s_p [NUM_GROUPS];
  logic [NUM_GROUPS-1:0]               c_p;
  logic [NUM_GROUPS-1:0][GROUP-1:0]    gsum;
  logic [NUM_GROUPS-1:0]               gcout;
  logic [WIDTH:1]                      s_next [NUM_GROUPS];
  logic                                c_into_msb;
  logic                                vld_out;
  logic [WIDTH:1]                      s_out;
  logic                                cout_out;
  logic                                ovf_out;

  assign advance   = !vld_out | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_out;
  assign S         = s_out;
  assign Cout      = cout_out;
  assign Ovf       = ovf_out;
  assign sub_mode  = (mode_e'(Sub) == SUB);

  // Stage k: group k adds its slice of rank k using the carry registered from stage k-1.
  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_stage
    carry_skip_group #(
      .GROUP(GROUP)
    ) u_grp (
      .a   (a_p[k][k*GROUP+GROUP : k*GROUP+1]),
      .b   (b_p[k][k*GROUP+GROUP : k*GROUP+1]),
      .cin (c_p[k]),
      .sum (gsum[k]),
      .cout(gcout[k])
    );
  end

  // Merge each stage's fresh group sum into the sum bits already completed below it.
  always_comb begin
    for (int k = 0; k < NUM_GROUPS; k++) begin
      s_next[k] = s_p[k];
      s_next[k][k*GROUP+1 +: GROUP] = gsum[k];
    end
  end

  // Carry into the top bit, recovered from the top bit's operands and sum.
  assign c_into_msb = a_p[NUM_GROUPS-1][WIDTH] ^ b_p[NUM_GROUPS-1][WIDTH]
                    ^ gsum[NUM_GROUPS-1][GROUP-1];

  // Datapath ranks: operand capture with mode folding, then skew/deskew shifting.
  always_ff @(posedge clk) begin
    if (advance) begin
      a_p[0] <= A;
      b_p[0] <= sub_mode ? ~B : B;
      c_p[0] <= sub_mode ? 1'b1 : Cin;
      s_p[0] <= '0;
      for (int k = 1; k < NUM_GROUPS; k++) begin
        a_p[k] <= a_p[k-1];
        b_p[k] <= b_p[k-1];
        c_p[k] <= gcout[k-1];
        s_p[k] <= s_next[k-1];
      end
    end
  end

  // Per-rank valid bits travel with the data; a cycle without in_valid is a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (advance) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < NUM_GROUPS; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // Output registers: hold while the consumer stalls, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out  <= 1'b0;
      s_out    <= '0;
      cout_out <= 1'b0;
      ovf_out  <= 1'b0;
    end else if (advance) begin
      vld_out  <= vld_p[NUM_GROUPS-1];
      s_out    <= s_next[NUM_GROUPS-1];
      cout_out <= gcout[NUM_GROUPS-1];
      ovf_out  <= c_into_msb ^ gcout[NUM_GROUPS-1];
    end
  end

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Self-checking bench for pipelined_carry_skip_adder (WIDTH=16, GROUP=4).
module tb_pipelined_carry_skip_adder;

  localparam int WIDTH = 16;
  localparam int GROUP = 4;
  localparam int LAT   = WIDTH / GROUP;

  typedef logic [WIDTH+1:0] res_t;   // {S, Cout, Ovf}

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  res_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  pipelined_carry_skip_adder #(
    .WIDTH(WIDTH),
    .GROUP(GROUP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Sub      (Sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .Cout     (Cout),
    .Ovf      (Ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic             c;
    logic [WIDTH:0]   full;
    logic             ovf;
    bb   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
    ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {full[WIDTH-1:0], full[WIDTH], ovf};
  endfunction

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom % 6)
      0:       return '0;
      1:       return '1;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("sb_unexpected_out", 32'(sb_q.size()), 32'd1);
        else chk("sb", 32'({S, Cout, Ovf}), 32'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) sb_q.push_back(model(A, B, Cin, Sub));
    end
  end

  // Present one transaction and wait for its accepting edge; leaves in_valid high.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
    bit acc = 1'b0;
    int t   = 0;
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) chk("send_timeout", 32'(t), 32'd0);
  endtask

  // Single transaction into an empty pipeline: check latency and the result.
  task automatic send_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input res_t exp, input string tag);
    int cnt = 0;
    send(a, b, cin, sub);
    in_valid = 1'b0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, 32'(cnt), 32'(LAT));
    chk(tag, 32'({S, Cout, Ovf}), 32'(exp));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    int last;
    int nv;
    int t;

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_S",         32'(S),         32'd0);
    chk("rst_Cout",      32'(Cout),      32'd0);
    chk("rst_Ovf",       32'(Ovf),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases
    send_lat(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0}, "skip_chain");
    send_lat(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1}, "pos_ovf");
    send_lat(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0}, "sub_neg");
    send_lat(16'h00FF, 16'h0F00, 1'b1, 1'b0, {16'h1000, 1'b0, 1'b0}, "cin_add");
    send_lat(16'h8000, 16'h0001, 1'b1, 1'b1, {16'h7FFF, 1'b1, 1'b1}, "sub_ovf");

    // Back-to-back stream of 8
    first = -1; last = -1; nv = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 1'($urandom % 2), 1'($urandom % 2));
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (out_valid) begin
            if (first < 0) first = c;
            last = c;
            nv++;
          end
        end
      end
    join
    chk("b2b_count",  32'(nv),             32'd8);
    chk("b2b_contig", 32'(last - first + 1), 32'd8);
    chk("b2b_first",  32'(first),          32'(LAT));

    // Stall with a full pipeline
    out_ready = 1'b0;
    for (int i = 0; i < LAT + 1; i++) send(rnd_op(), rnd_op(), 1'($urandom % 2), 1'($urandom % 2));
    A = 16'h1357; B = 16'h2468; Cin = 1'b1; Sub = 1'b0; in_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_hold",      32'({S, Cout, Ovf}), 32'(sb_q[0]));
      chk("stall_depth",     32'(sb_q.size()), 32'(LAT + 1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stall_drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset with transactions in flight
    send(rnd_op(), rnd_op(), 1'b0, 1'b0);
    send(rnd_op(), rnd_op(), 1'b0, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_S", 32'(S), 32'd0);
    for (int c = 0; c < 8; c++) begin
      chk("rst_flush_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    send_lat(16'h1111, 16'h2222, 1'b0, 1'b0, {16'h3333, 1'b0, 1'b0}, "post_rst");

    // Random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom % 4 == 0) begin
            in_valid = 1'b0;
            repeat ($urandom % 3 + 1) @(posedge clk);
            #1;
          end
          send(rnd_op(), rnd_op(), 1'($urandom % 2), 1'($urandom % 2));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (!done) out_ready = ($urandom % 4) != 0;
        end
        out_ready = 1'b1;
      end
    join
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("final_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_skip_adder.md
PIPELINED_CARRY_SKIP_ADDER -- requirements
Module: pipelined_carry_skip_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter GROUP, default 4, carry-skip group size in bits; WIDTH SHALL be a multiple of GROUP; NUM_GROUPS = WIDTH/GROUP.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, operand transfer request.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands this cycle.
REQ-007 SHALL have ports A and B, input, WIDTH each, operands with bit range [WIDTH:1].
REQ-008 SHALL have port Cin, input, 1, carry-in for add mode.
REQ-009 SHALL have port Sub, input, 1, mode select: 0 = A+B+Cin, 1 = A-B.
REQ-010 SHALL have port out_valid, output, 1, result held on S/Cout/Ovf is valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port S, output, WIDTH, sum with bit range [WIDTH:1].
REQ-013 SHALL have port Cout, output, 1, carry out of bit WIDTH.
REQ-014 SHALL have port Ovf, output, 1, signed (two's-complement) overflow.

Function
REQ-015 SHALL be a NUM_GROUPS-stage pipeline: stage k (k = 0 .. NUM_GROUPS-1) resolves sum bits [k*GROUP+GROUP : k*GROUP+1] from that group's bitwise P/G and the registered carry from stage k-1.
REQ-016 SHALL use, in each stage, group propagate = AND of the group's P bits; group carry-out = group P ? carry-in : ripple carry-out (skip mux).
REQ-017 SHALL skew-register operand bits of groups above k and deskew-register completed sum bits below k, so all bits of one transaction leave together.
REQ-018 SHALL, in Sub mode, use ~B as the second operand with effective carry-in 1, ignoring Cin; the mode is captured per transaction at acceptance.
REQ-019 SHALL compute Ovf = carry into bit WIDTH XOR Cout.
REQ-020 SHALL, with no stalls, give a latency of exactly NUM_GROUPS cycles from the accepting edge (in_valid & in_ready) to out_valid=1 with that result, at a throughput of 1 transaction per cycle.
REQ-021 SHALL define advance = !out_valid | out_ready; in_ready = advance; all stage registers, including per-stage valid bits, load only when advance=1.
REQ-022 SHALL hold S, Cout, Ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL advance a cycle with in_valid=0 while advance=1, inserting a bubble (stage valid=0); bubbles never assert out_valid.
REQ-024 SHALL, when output acceptance and new input acceptance occur in the same cycle, perform both with no lost or duplicated result.
REQ-025 SHALL produce results modulo 2^WIDTH; carry wrap-around appears only on Cout.
REQ-026 SHALL, with NUM_GROUPS = 1, degenerate to a single registered stage with a latency of 1.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, clear all stage valid bits; out_valid=0, S=0, Cout=0, Ovf=0 on the following cycle.
REQ-028 SHALL discard in-flight transactions when rst is asserted mid-operation; no partial result emerges after reset.
REQ-029 SHALL drive in_ready=1 during and after reset, since out_valid=0.

Structure
REQ-030 SHALL place shared package adder_pkg (NUM_GROUPS function, mode encoding constants ADD=0/SUB=1) alongside the existing adder utilities.
REQ-031 SHALL implement one sub-module carry_skip_group (GROUP-bit P/G, ripple, skip mux, sum), instantiated NUM_GROUPS times by generate.
REQ-032 SHALL keep the datapath fully combinational inside carry_skip_group; all registers live in the top level.

Verification (WIDTH=16, GROUP=4, latency 4)
REQ-033 SHALL verify: A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> 4 cycles later S=0x0000, Cout=1, Ovf=0 (full skip chain).
REQ-034 SHALL verify: A=0x7FFF, B=0x0001, Sub=0 -> S=0x8000, Cout=0, Ovf=1; A=0x0005, B=0x0007, Sub=1 -> S=0xFFFE, Cout=0, Ovf=0.
REQ-035 SHALL verify: back-to-back stream of 8 random transactions with out_ready=1 -> 8 consecutive out_valid cycles, in order, matching the reference model.
REQ-036 SHALL verify: out_ready=0 for 3 cycles with a full pipeline -> in_ready=0, outputs frozen, no loss; on release the results drain in order.
REQ-037 SHALL verify: rst pulsed 2 cycles after 2 acceptances -> out_valid stays 0 until a new post-reset transaction completes 4 cycles later.
REQ-038 SHALL verify: 1000 random transactions with random in_valid/out_ready -> scoreboard matches A+B+Cin or A-B for every transaction, including Cout and Ovf.
